// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU with
// a pending-result register, MTHI/MTLO writes and a combinational MFHI/MFLO read port.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic        Write,
  input  logic        Addr,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [31:0]   hi_r, hi_n, lo_r, lo_n;
  logic [63:0]   pend_r, pend_n;
  logic          pend_wr_r, pend_wr_n;
  logic          busy_r;
  logic          accept_s;
  logic [63:0]   smul_s, umul_s;
  logic [31:0]   abs_a_s, abs_b_s, uq_s, ur_s, mq_s, mr_s, sq_s, sr_s;

  // Arithmetic datapath; signed divide works on magnitudes so INT_MIN / -1 wraps cleanly
  always_comb begin
    smul_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    umul_s  = {32'd0, A} * {32'd0, B};
    abs_a_s = A[31] ? (32'd0 - A) : A;
    abs_b_s = B[31] ? (32'd0 - B) : B;
    if (B == 32'd0) begin
      uq_s = 32'd0;
      ur_s = 32'd0;
      mq_s = 32'd0;
      mr_s = 32'd0;
    end else begin
      uq_s = A / B;
      ur_s = A % B;
      mq_s = abs_a_s / abs_b_s;
      mr_s = abs_a_s % abs_b_s;
    end
    sq_s = (A[31] ^ B[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s = A[31] ? (32'd0 - mr_s) : mr_s;
  end

  // Next-state logic: accept, countdown, write-back on the last busy cycle, MT writes
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    hi_n      = hi_r;
    lo_n      = lo_r;
    pend_n    = pend_r;
    pend_wr_n = pend_wr_r;
    accept_s  = Start & ~Cancel & ~Op[2] & (state_r == IDLE);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = RUN;
          cnt_n   = Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          case (Op[1:0])
            2'b00: begin pend_n = umul_s;       pend_wr_n = 1'b1; end
            2'b01: begin pend_n = smul_s;       pend_wr_n = 1'b1; end
            2'b10: begin pend_n = {ur_s, uq_s}; pend_wr_n = (B != 32'd0); end
            2'b11: begin pend_n = {sr_s, sq_s}; pend_wr_n = (B != 32'd0); end
            default: begin pend_n = 64'd0;      pend_wr_n = 1'b0; end
          endcase
        end else if (Write & ~Cancel & ~Start) begin
          if (Addr) begin
            lo_n = A;
          end else begin
            hi_n = A;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        cnt_n = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_n = IDLE;
          if (pend_wr_r) begin
            {hi_n, lo_n} = pend_r;
          end else begin
            {hi_n, lo_n} = {hi_r, lo_r};
          end
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CW{1'b0}};
      end
    endcase
  end

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_r    <= 64'd0;
      pend_wr_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      hi_r      <= hi_n;
      lo_r      <= lo_n;
      pend_r    <= pend_n;
      pend_wr_r <= pend_wr_n;
      busy_r    <= (cnt_n != {CW{1'b0}});
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;
  assign RD   = Addr ? lo_r : hi_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random operations checked
// against an arithmetic HI/LO model kept in the bench.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic        Write = 1'b0;
  logic        Addr = 1'b0;
  logic        Cancel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO, RD;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Write(Write), .Addr(Addr),
    .Cancel(Cancel), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .RD(RD)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish earlier", $time);
    $fatal(1);
  end

  // Reference: what HI/LO become after the operation completes
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 3'd0) begin
      p = ua * ub;
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (op == 3'd1) begin
      q = sa * sb;
      m_hi = q[63:32]; m_lo = q[31:0];
    end else if (b != 32'd0) begin
      if (op == 3'd2) begin
        m_lo = a / b; m_hi = a % b;
      end else begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    return op[1] ? 10 : 5;
  endfunction

  // Drive one Start cycle from the current negedge; returns at the next negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt_write(input logic addr, input logic [31:0] d);
    Write = 1'b1; Addr = addr; A = d;
    @(negedge clk);
    Write = 1'b0;
    if (addr) m_lo = d; else m_hi = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    Addr = 1'b0;
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'd0); end
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", LO, 32'd0); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (RD !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h exp=%h", RD, 32'd0); end
  endtask

  task automatic test_mult();
    int n;
    logic [31:0] old_hi;
    logic [2:0] ops [2] = '{3'd1, 3'd0};
    for (int i = 0; i < 2; i++) begin
      old_hi = m_hi;
      model_op(ops[i], 32'hFFFFFFFD, 32'd5);
      Addr = 1'b0;
      issue(ops[i], 32'hFFFFFFFD, 32'd5);
      total++; if (RD !== old_hi) begin bad++; $display("FAIL mult_rd_during_run got=%h exp=%h", RD, old_hi); end
      wait_done(n);
      total++; if (n != 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
      total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL mult_result op=%0d got=%h_%h exp=%h_%h", ops[i], HI, LO, m_hi, m_lo); end
    end
    total++; if (HI !== 32'h00000004 || LO !== 32'hFFFFFFF1) begin bad++; $display("FAIL multu_const got=%h_%h exp=00000004_fffffff1", HI, LO); end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] da [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h55};
    logic [31:0] db [4] = '{32'd7,   32'd2,        32'hFFFFFFFF, 32'd0};
    logic [2:0]  dop[4] = '{3'd2,    3'd3,         3'd3,         3'd3};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mt_write(1'b0, 32'h1234);
        mt_write(1'b1, 32'h1234);
      end
      model_op(dop[i], da[i], db[i]);
      issue(dop[i], da[i], db[i]);
      wait_done(n);
      total++; if (n != 10) begin bad++; $display("FAIL div_busy_cycles case=%0d got=%0d exp=10", i, n); end
      total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL div_result case=%0d got=%h_%h exp=%h_%h", i, HI, LO, m_hi, m_lo); end
    end
    total++; if (HI !== 32'h1234 || LO !== 32'h1234) begin bad++; $display("FAIL div_by_zero got=%h_%h exp=00001234_00001234", HI, LO); end
  endtask

  task automatic test_mt();
    int n;
    mt_write(1'b0, 32'hDEADBEEF);
    Addr = 1'b0;
    total++; if (HI !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi got=%h exp=deadbeef", HI); end
    total++; if (RD !== 32'hDEADBEEF) begin bad++; $display("FAIL mfhi_rd got=%h exp=deadbeef", RD); end
    Addr = 1'b1;
    #1;
    total++; if (RD !== m_lo) begin bad++; $display("FAIL mflo_rd got=%h exp=%h", RD, m_lo); end
    model_op(3'd0, 32'd3, 32'd9);
    issue(3'd0, 32'd3, 32'd9);
    Write = 1'b1; Addr = 1'b1; A = 32'hA5A5A5A5;
    @(negedge clk);
    Write = 1'b0;
    total++; if (LO === 32'hA5A5A5A5) begin bad++; $display("FAIL mtlo_busy got=%h exp=not a5a5a5a5", LO); end
    wait_done(n);
    total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL mtlo_busy_final got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_cancel_illegal();
    Cancel = 1'b1;
    issue(3'd1, 32'd7, 32'd7);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", Busy); end
    Cancel = 1'b1;
    Write = 1'b1; Addr = 1'b0; A = 32'h0BADF00D;
    @(negedge clk);
    Write = 1'b0; Cancel = 1'b0;
    total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL cancel_hilo got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo); end
    issue(3'b101, 32'd7, 32'd7);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b exp=0", Busy); end
    repeat (12) @(negedge clk);
    total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL illegal_hilo got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom | 32'd1;
      model_op(3'(i % 4), a, b);
      issue(3'(i % 4), a, b);
      wait_done(n);
      total++; if (n != lat(3'(i % 4))) begin bad++; $display("FAIL b2b_cycles step=%0d got=%0d exp=%0d", i, n, lat(3'(i % 4))); end
      total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL b2b_result step=%0d got=%h_%h exp=%h_%h", i, HI, LO, m_hi, m_lo); end
    end
  endtask

  task automatic test_random();
    int n;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      model_op(op, a, b);
      issue(op, a, b);
      wait_done(n);
      total++; if (n != lat(op)) begin bad++; $display("FAIL rand_cycles i=%0d got=%0d exp=%0d", i, n, lat(op)); end
      total++; if (HI !== m_hi || LO !== m_lo) begin bad++; $display("FAIL rand_result i=%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, HI, LO, m_hi, m_lo); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    mt_write(1'b0, 32'h11111111);
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL midreset_hilo got=%h_%h exp=0_0", HI, LO); end
    repeat (15) @(negedge clk);
    total++; if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin bad++; $display("FAIL midreset_late got=%h_%h busy=%b exp=0_0 busy=0", HI, LO, Busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
